// File: rtl/proc_test_sequencer_pkg.sv
// proc_test_pkg: state encoding and shared constants for the processor test sequencer
package proc_test_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RESET_PROC, S_RUN, S_SCAN, S_DONE} state_e;
  localparam int FIRST_REG = 1;
  localparam logic [63:0] CNT_MAX = '1;
endpackage

// File: rtl/proc_test_sequencer_if.sv
// proc_test_if: processor control plus register-file / expected-ROM debug read port
interface proc_test_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              proc_reset;
  logic              proc_en;
  logic [ADDR_W-1:0] dbg_addr;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] exp_data;
  modport master (output proc_reset, proc_en, dbg_addr, exp_addr, input dbg_data, exp_data);
  modport slave  (input proc_reset, proc_en, dbg_addr, exp_addr, output dbg_data, exp_data);
endinterface

// File: rtl/proc_test_sequencer_compare.sv
// test_compare_pipe: aligns issued index with read data, counts mismatches and captures the first
module test_compare_pipe
  import proc_test_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              issue,
  input  logic              active,
  input  logic [ADDR_W-1:0] issue_idx,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              mismatch,
  output logic              last,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_actual,
  output logic [DATA_W-1:0] fail_expected
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d, fidx_q, fidx_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] fact_q, fact_d, fexp_q, fexp_d;
  logic              first;
  always_comb begin
    mismatch = valid_q && active && dbg_data != exp_data;
    last     = valid_q && active && idx_q == ADDR_W'(NREGS - 1);
    first    = mismatch && err_q == '0;
    valid_d  = issue && !clear;
    idx_d    = issue_idx;
    err_d    = clear ? '0 : (mismatch && err_q != CNT_W'(CNT_MAX)) ? err_q + 1'b1 : err_q;
    fidx_d   = clear ? '0 : first ? idx_q : fidx_q;
    fact_d   = clear ? '0 : first ? dbg_data : fact_q;
    fexp_d   = clear ? '0 : first ? exp_data : fexp_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fact_q  <= '0;
      fexp_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fact_q  <= fact_d;
      fexp_q  <= fexp_d;
    end
  assign err_count     = err_q;
  assign fail_idx      = fidx_q;
  assign fail_actual   = fact_q;
  assign fail_expected = fexp_q;
endmodule

// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: resets, runs and freezes the core, then scans its registers against an expected ROM
module proc_test_sequencer
  import proc_test_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NREGS        = 32,
  parameter int ADDR_W       = 5,
  parameter int CYCLE_W      = 16,
  parameter int RESET_CYCLES = 1,
  parameter int CNT_W        = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic               stop_on_fail,
  proc_test_if.master        bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [ADDR_W-1:0]  fail_idx,
  output logic [DATA_W-1:0]  fail_actual,
  output logic [DATA_W-1:0]  fail_expected
);
  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d, rc_q, rc_d;
  logic [ADDR_W-1:0]  dbg_addr_q, dbg_addr_d;
  logic               stop_q, stop_d, proc_reset_q, proc_reset_d, proc_en_q, proc_en_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic               accept, mismatch, last;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rc_d         = rc_q;
    stop_d       = stop_q;
    dbg_addr_d   = dbg_addr_q;
    proc_reset_d = proc_reset_q;
    proc_en_d    = proc_en_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    accept       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE:
        if (start) begin
          accept       = 1'b1;
          state_d      = S_RESET_PROC;
          cnt_d        = '0;
          rc_d         = run_cycles;
          stop_d       = stop_on_fail;
          proc_reset_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      S_RESET_PROC:
        if (cnt_q == CYCLE_W'(RESET_CYCLES - 1)) begin
          state_d      = rc_q == '0 ? S_SCAN : S_RUN;
          cnt_d        = '0;
          proc_reset_d = 1'b0;
          proc_en_d    = rc_q != '0;
          dbg_addr_d   = rc_q == '0 ? ADDR_W'(FIRST_REG) : '0;
        end else cnt_d = cnt_q + 1'b1;
      S_RUN:
        if (cnt_q == rc_q - 1'b1) begin
          state_d    = S_SCAN;
          proc_en_d  = 1'b0;
          dbg_addr_d = ADDR_W'(FIRST_REG);
        end else cnt_d = cnt_q + 1'b1;
      S_SCAN: begin
        // address 0 after the last issue marks the drain cycle of the compare pipe
        dbg_addr_d = (dbg_addr_q == '0 || dbg_addr_q == ADDR_W'(NREGS - 1)) ? '0 : dbg_addr_q + 1'b1;
        if (last || (stop_q && mismatch)) begin
          state_d      = S_DONE;
          dbg_addr_d   = '0;
          proc_reset_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          pass_d       = err_count == '0 && !mismatch;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rc_q         <= '0;
      stop_q       <= 1'b0;
      dbg_addr_q   <= '0;
      proc_reset_q <= 1'b1;
      proc_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rc_q         <= rc_d;
      stop_q       <= stop_d;
      dbg_addr_q   <= dbg_addr_d;
      proc_reset_q <= proc_reset_d;
      proc_en_q    <= proc_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  test_compare_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .CNT_W(CNT_W)) u_cmp (
    .clk(clk),
    .rst_n(reset),
    .clear(accept),
    .issue(state_q == S_SCAN && dbg_addr_q != '0),
    .active(state_q == S_SCAN),
    .issue_idx(dbg_addr_q),
    .dbg_data(bus.dbg_data),
    .exp_data(bus.exp_data),
    .mismatch(mismatch),
    .last(last),
    .err_count(err_count),
    .fail_idx(fail_idx),
    .fail_actual(fail_actual),
    .fail_expected(fail_expected)
  );
  assign bus.proc_reset = proc_reset_q;
  assign bus.proc_en    = proc_en_q;
  assign bus.dbg_addr   = dbg_addr_q;
  assign bus.exp_addr   = dbg_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
endmodule

// File: tb/tb_proc_test_sequencer.sv
// tb_proc_test_sequencer: scoreboarded random and directed tests of the processor test sequencer
module tb_proc_test_sequencer;
  localparam int NREGS = 32;
  localparam int RC    = 1;
  typedef struct {
    int          lat;
    int          en;
    int          pass;
    int          err;
    int          idx;
    logic [31:0] act;
    logic [31:0] expv;
  } exp_t;
  logic        clk = 0, reset = 1, start = 0, stop_on_fail = 0;
  logic [15:0] run_cycles = 0;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic [4:0]  fail_idx;
  logic [31:0] fail_actual, fail_expected;
  logic [31:0] regs[NREGS];
  logic [31:0] rom[NREGS];
  exp_t        exp_q[$];
  int          errors = 0, checks = 0, cyc = 0, start_cyc = 0, en_cnt = 0;
  bit          done_prev = 0;
  proc_test_if #(.DATA_W(32), .ADDR_W(5)) pif ();
  proc_test_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .stop_on_fail(stop_on_fail),
    .bus(pif), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_idx(fail_idx), .fail_actual(fail_actual), .fail_expected(fail_expected)
  );
  always #5 clk = ~clk;
  // register file and expected ROM, both with a one-cycle synchronous read
  always @(posedge clk) begin
    pif.dbg_data <= regs[pif.dbg_addr];
    pif.exp_data <= rom[pif.exp_addr];
  end
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(negedge clk); if (pif.proc_en) en_cnt++; end
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("latency", cyc - start_cyc, e.lat);
          chk("proc_en_cycles", en_cnt, e.en);
          chk("pass", pass, e.pass);
          chk("err_count", err_count, e.err);
          chk("fail_idx", fail_idx, e.idx);
          chk("fail_actual", fail_actual, e.act);
          chk("fail_expected", fail_expected, e.expv);
          chk("busy_in_done", busy, 0);
          chk("proc_reset_in_done", pif.proc_reset, 1);
          chk("dbg_addr_in_done", pif.dbg_addr, 0);
        end
      end
      done_prev = done;
    end
  end
  function automatic exp_t model(input int rc, input bit stop);
    exp_t e = '{default: 0};
    int   k = NREGS;
    e.pass = 1;
    for (int i = 1; i < NREGS; i++)
      if (regs[i] != rom[i]) begin
        if (e.err == 0) begin e.idx = i; e.act = regs[i]; e.expv = rom[i]; end
        e.err  = e.err < 63 ? e.err + 1 : 63;
        e.pass = 0;
        if (stop) begin k = i + 1; break; end
      end
    e.lat = RC + rc + k;
    e.en  = rc;
    return e;
  endfunction
  task automatic fill(input int pct);
    for (int i = 0; i < NREGS; i++) begin
      rom[i]  = $urandom;
      regs[i] = ($urandom_range(0, 99) < pct) ? rom[i] ^ (32'h1 << $urandom_range(0, 31)) : rom[i];
    end
    regs[0] = ~rom[0];
  endtask
  task automatic issue_test(input int rc, input bit stop);
    exp_t e = model(rc, stop);
    @(negedge clk);
    run_cycles = 16'(rc); stop_on_fail = stop; start = 1;
    @(posedge clk); #1;
    start = 0; start_cyc = cyc; en_cnt = 0;
    exp_q.push_back(e);
  endtask
  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles", n);
      exp_q.delete();
    end
  endtask
  task automatic run_test(input int rc, input bit stop);
    issue_test(rc, stop);
    wait_done();
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_proc_reset"}, pif.proc_reset, 1);
    chk({tag, "_proc_en"}, pif.proc_en, 0);
    chk({tag, "_dbg_addr"}, pif.dbg_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_fail_idx"}, fail_idx, 0);
    chk({tag, "_fail_actual"}, fail_actual, 0);
    chk({tag, "_fail_expected"}, fail_expected, 0);
  endtask
  initial begin
    int n;
    fill(0);
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) reset = 1;
    run_test(24, 0);
    fill(0);
    regs[7] = 32'hcafebabe; rom[7] = 32'h00000015; regs[20] = rom[20] + 1;
    run_test(10, 1);
    fill(0);
    regs[3] ^= 32'h1; regs[9] ^= 32'h8000_0000; regs[31] ^= 32'h0001_0000;
    run_test(5, 0);
    fill(0);
    run_test(0, 0);
    fill(0);
    regs[5] ^= 32'h4;
    run_test(3, 0);
    @(negedge clk); run_cycles = 30; stop_on_fail = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (RC + 10) @(posedge clk);
    #1 chk("proc_en_mid_run", pif.proc_en, 1);
    #1 reset = 0;
    #1 check_reset_vals("mid_run_reset");
    @(negedge clk) reset = 1;
    run_test(12, 0);
    fill(5);
    issue_test(8, 0);
    n = 0;
    while (pif.dbg_addr == 0 && n < 200) begin @(negedge clk); n++; end
    chk("reached_scan", pif.dbg_addr != 0, 1);
    repeat (4) @(negedge clk);
    run_cycles = 99; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    repeat (150) @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      fill($urandom_range(0, 15));
      run_test($urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/proc_test_sequencer.md
Name: proc_test_sequencer

Overview:
- Synthesizable, parametrised self-checking harness for the MIPS core.
- Holds the processor in reset, then runs it for a programmable number of cycles and freezes it.
- Then scans every architectural register through a debug read port and compares each one against an expected-value ROM.
- Reports pass/fail, mismatch count and first-failure details; allows on-board and FPGA regression of test programs without a simulator.

Parameters:
- DATA_W, 32, register and expected-value width
- NREGS, 32, number of architectural registers; register 0 is never checked
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NREGS
- CYCLE_W, 16, width of the run-cycle budget
- RESET_CYCLES, 1, cycles proc_reset is held high before the run; must be >= 1
- CNT_W, 6, width of the mismatch counter; saturates at all-ones

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low block reset (0 = reset)
- start  in  1  begin a test; sampled only in IDLE and DONE
- run_cycles  in  CYCLE_W  processor cycles to execute; sampled with start
- stop_on_fail  in  1  1 = abort scan at first mismatch; 0 = scan all and count; sampled with start
- proc_reset  out  1  active-high reset to the processor
- proc_en  out  1  processor clock enable; high only in RUN
- dbg_addr  out  ADDR_W  register index to the register-file debug read port
- dbg_data  in  DATA_W  register content; valid one cycle after dbg_addr
- exp_addr  out  ADDR_W  expected-ROM address; always equal to dbg_addr
- exp_data  in  DATA_W  expected content; valid one cycle after exp_addr
- busy  out  1  high in RESET_PROC, RUN and SCAN
- done  out  1  level; high in DONE until the next accepted start
- pass  out  1  valid while done; 1 = zero mismatches
- err_count  out  CNT_W  number of mismatches found
- fail_idx  out  ADDR_W  index of the first mismatch
- fail_actual  out  DATA_W  register value at the first mismatch
- fail_expected  out  DATA_W  expected value at the first mismatch

Behaviour:
- Reset values (reset low, asynchronous): state IDLE; proc_reset=1, proc_en=0, dbg_addr=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, fail_actual=0, fail_expected=0.
- Reset asserted mid-operation: immediate return to IDLE; no partial result is retained.
- States: IDLE, RESET_PROC, RUN, SCAN, DONE.
- IDLE/DONE, start=1: latch run_cycles and stop_on_fail; clear err_count and all fail_* fields; clear done and pass; go to RESET_PROC.
- RESET_PROC: proc_reset=1, proc_en=0 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: proc_reset=0, proc_en=1 for exactly run_cycles cycles, then go to SCAN. If run_cycles=0, go directly from RESET_PROC to SCAN.
- SCAN: proc_en=0 and proc_reset=0, so processor state is frozen.
  - Issue addresses 1..NREGS-1, one per cycle.
  - The compare for address k happens in the following cycle (pipelined), so SCAN lasts NREGS cycles.
- Mismatch is dbg_data != exp_data. On each mismatch, err_count increments (saturating).
- On the first mismatch, fail_idx, fail_actual and fail_expected are captured; later mismatches do not overwrite them.
- stop_on_fail=1: the first mismatch ends SCAN on that compare edge; remaining addresses are not compared.
- Leaving SCAN: go to DONE; done=1; pass = (err_count==0); proc_reset returns to 1.
- Timing: counting the edge that samples start as edge 0, done is high after edge RESET_CYCLES + run_cycles + NREGS when there is no early abort.
- start while busy is ignored.
- start held high in DONE restarts immediately.
- In IDLE and DONE, dbg_addr = 0.

Decomposition:
- Shared package proc_test_pkg holds:
  - the state encoding typedef;
  - localparam FIRST_REG = 1;
  - the saturation constant CNT_MAX.
- One natural sub-module, test_compare_pipe: the one-cycle address-to-data alignment stage plus the first-fail capture and saturating counter.
- The FSM and cycle counters stay in the top module.

Test Plan:
- All match: RESET_CYCLES=1, run_cycles=24, expected ROM equals the register model -> done after edge 24+1+32=57, pass=1, err_count=0, proc_en high for exactly 24 cycles.
- First-fail abort: stop_on_fail=1, reg 7 = 0xcafebabe vs expected 0x00000015 -> fail_idx=7, fail_actual=0xcafebabe, fail_expected=0x00000015, err_count=1, done 7 compare cycles into SCAN.
- Count mode: stop_on_fail=0, mismatches at regs 3, 9, 31 -> err_count=3, fail_idx=3, pass=0, full NREGS-cycle scan.
- Zero budget: run_cycles=0 -> proc_en never asserted; SCAN starts right after RESET_PROC; done after edge 1+0+32=33.
- Reset mid-RUN: pull reset low at cycle 10 of RUN -> all outputs return to reset values in the same cycle; the next start runs the full sequence with a fresh err_count=0.
- Busy start: pulse start during SCAN -> ignored, no restart; run_cycles latched at the original start is unchanged.
